// File: rtl/prog_load_seq.sv
// Host-side program loader / result reader for the accumulator processor.
// Loads a header, program words and operand words from a valid/ready stream
// into IM/DM, kicks the control unit, waits for it, then streams a window of
// DM back out. Owns the memory ports in every state except RUN.
`timescale 1ns/1ps
module prog_load_seq #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              start_process,
    input  logic              end_process,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);
    // Counters carry one extra bit so a full-depth length (2**ADDR_W) fits.
    localparam int CW = ADDR_W + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DATA_W:0] DEPTH_W = (DATA_W+1)'(1) << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_LOAD_IM, S_LOAD_DM, S_START, S_RUN,
        S_RD_ADDR, S_RD_DATA, S_RD_OUT, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     n_q, n_d, m_q, m_d, r_q, r_d;
    logic [ADDR_W-1:0] b_q, b_d;
    logic              bad_q, bad_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              in_xfer;
    logic              hdr_over;

    assign in_xfer  = in_valid & in_ready;
    // Header length fields are compared at full word width so large values
    // cannot alias into range after truncation.
    assign hdr_over = {1'b0, in_data} > DEPTH_W;

    // Next-state and datapath update for the session sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        m_d         = m_q;
        r_d         = r_q;
        b_d         = b_q;
        bad_d       = bad_q;
        tmo_d       = tmo_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (host_start) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    bad_d   = 1'b0;
                end
            end
            S_HDR: begin
                if (in_xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    case (cnt_q[1:0])
                        2'd0: begin
                            n_d = in_data[CW-1:0];
                            if (in_data == '0 || hdr_over) bad_d = 1'b1;
                        end
                        2'd1: begin
                            m_d = in_data[CW-1:0];
                            if (hdr_over) bad_d = 1'b1;
                        end
                        2'd2: b_d = in_data[ADDR_W-1:0];
                        default: begin
                            r_d     = in_data[CW-1:0];
                            cnt_d   = '0;
                            state_d = (bad_q || hdr_over) ? S_ERR : S_LOAD_IM;
                        end
                    endcase
                end
            end
            S_LOAD_IM: begin
                if (in_xfer) begin
                    if (cnt_q == n_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = (m_q != '0) ? S_LOAD_DM : S_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_DM: begin
                if (in_xfer) begin
                    if (cnt_q == m_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                tmo_d   = '0;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (end_process) begin
                    state_d = (r_q != '0) ? S_RD_ADDR : S_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                out_data_d  = dm_rdata;
                out_valid_d = 1'b1;
                state_d     = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = (cnt_q + 1'b1 == r_q) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any session immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            m_q         <= '0;
            r_q         <= '0;
            b_q         <= '0;
            bad_q       <= 1'b0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            m_q         <= m_d;
            r_q         <= r_d;
            b_q         <= b_d;
            bad_q       <= bad_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Memory ports and status decoded from the registered state; write data
    // is zeroed when not writing so idle ports stay quiet.
    always_comb begin
        in_ready      = (state_q == S_HDR) || (state_q == S_LOAD_IM) || (state_q == S_LOAD_DM);
        im_we         = (state_q == S_LOAD_IM) && in_valid;
        im_addr       = (state_q == S_LOAD_IM) ? cnt_q[ADDR_W-1:0] : '0;
        im_wdata      = im_we ? in_data : '0;
        dm_we         = (state_q == S_LOAD_DM) && in_valid;
        dm_wdata      = dm_we ? in_data : '0;
        dm_addr       = '0;
        if (state_q == S_LOAD_DM)
            dm_addr = cnt_q[ADDR_W-1:0];
        else if (state_q == S_RD_ADDR || state_q == S_RD_DATA)
            dm_addr = b_q + cnt_q[ADDR_W-1:0];
        start_process = (state_q == S_START);
        done          = (state_q == S_DONE);
        error         = (state_q == S_ERR);
        busy          = (state_q != S_IDLE) && (state_q != S_ERR);
        out_valid     = out_valid_q;
        out_data      = out_data_q;
    end

endmodule

// File: tb/tb_prog_load_seq.sv
// Directed-session bench for prog_load_seq with randomized data, handshake
// gaps and sink stalls, checked against a simple memory/session model.
`timescale 1ns/1ps
module tb_prog_load_seq;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_start = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, im_we, dm_we, start_process, out_valid, busy, done, error;
    logic [AW-1:0] im_addr, dm_addr;
    logic [DW-1:0] im_wdata, dm_wdata, dm_rdata, out_data;
    logic          end_process = 1'b0, out_ready = 1'b0;

    always #5 clk = ~clk;

    prog_load_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .host_start(host_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .start_process(start_process), .end_process(end_process),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error)
    );

    // Memories, control-unit write port and event counters.
    logic [DW-1:0] im_mem [256];
    logic [DW-1:0] dm_mem [256];
    logic          cu_we = 1'b0;
    logic [AW-1:0] cu_addr = '0;
    logic [DW-1:0] cu_data = '0;
    int im_wr_cnt = 0, dm_wr_cnt = 0, start_cnt = 0, done_cnt = 0, both_we = 0, cycle = 0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (im_we) begin im_mem[im_addr] <= im_wdata; im_wr_cnt <= im_wr_cnt + 1; end
        if (dm_we) begin dm_mem[dm_addr] <= dm_wdata; dm_wr_cnt <= dm_wr_cnt + 1; end
        else if (cu_we) dm_mem[cu_addr] <= cu_data;
        dm_rdata <= dm_mem[dm_addr];
        if (im_we && dm_we) both_we <= both_we + 1;
        if (start_process) start_cnt <= start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] ref_dm [256];
    logic [DW-1:0] fix_im[$], fix_dm[$], fix_cu[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [71:0] all_outs();
        return {in_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
                start_process, out_valid, out_data, busy, done, error};
    endfunction

    // One host session: header, IM words, DM words, control-unit model, readout.
    task automatic session(input int n, input int m, input int b, input int r,
                           input int dly, input int bp, input int vpct,
                           input bit hang, input int abort_at);
        logic [DW-1:0] imv[$], dmv[$], cuv[$], wq[$];
        logic [DW-1:0] prev;
        int s_im, s_dm, s_st, s_dn, idx, cyc, got, hold, limit, t0, stab_bad;
        bit good;
        good = (n >= 1 && n <= 256 && m <= 256 && r <= 256);
        s_im = im_wr_cnt; s_dm = dm_wr_cnt; s_st = start_cnt; s_dn = done_cnt;
        wq = '{16'(n), 16'(m), 16'(b), 16'(r)};
        if (good) begin
            for (int i = 0; i < n; i++) imv.push_back(fix_im.size() > 0 ? fix_im[i] : 16'($urandom));
            for (int i = 0; i < m; i++) dmv.push_back(fix_dm.size() > 0 ? fix_dm[i] : 16'($urandom));
            for (int i = 0; i < r; i++) cuv.push_back(fix_cu.size() > 0 ? fix_cu[i] : 16'($urandom));
            wq = {wq, imv, dmv};
        end
        fix_im.delete(); fix_dm.delete(); fix_cu.delete();
        limit = (abort_at > 0) ? abort_at : wq.size();

        host_start = 1'b1;
        tick();
        idx = 0; cyc = 0;
        while (idx < limit && cyc < 20000) begin
            in_valid = ($urandom_range(99) < vpct);
            in_data  = wq[idx];
            if (cyc > 0) host_start = 1'b0;
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; host_start = 1'b0;
        check("words_accepted", idx, limit);
        if (abort_at > 0) return;

        if (!good) begin
            check("hdr_err_state", {error, busy, in_ready, out_valid}, 4'b1000);
            tick(); tick();
            check("hdr_no_writes", (im_wr_cnt - s_im) + (dm_wr_cnt - s_dm), 0);
            return;
        end

        check("start_pulse", {start_process, busy}, 2'b11);
        t0 = cycle;
        for (int i = 0; i < n; i++) check("im_content", im_mem[i], imv[i]);
        for (int i = 0; i < m; i++) check("dm_content", dm_mem[i], dmv[i]);
        for (int i = 0; i < m; i++) ref_dm[i] = dmv[i];
        for (int k = 0; k < r; k++) ref_dm[(b + k) % 256] = cuv[k];

        if (dly == 0) end_process = !hang;
        for (int i = 0; i < dly; i++) begin
            cu_we = (i < r);
            if (i < r) begin cu_addr = 8'((b + i) % 256); cu_data = cuv[i]; end
            tick();
        end
        cu_we = 1'b0;
        end_process = !hang;

        if (hang) begin
            cyc = 0;
            while (!error && cyc < 400) begin tick(); cyc++; end
            check("timeout_cycles", cycle - t0, TMO + 1);
            check("timeout_state", {error, busy}, 2'b10);
            check("timeout_one_start", start_cnt - s_st, 1);
            return;
        end

        got = 0; hold = 0; cyc = 0; stab_bad = 0; prev = '0;
        while (got < r && cyc < 4000) begin
            out_ready = (bp == 0) ? 1'b1 : (out_valid && hold >= bp);
            if (out_valid && out_ready) begin
                check("rd_data", out_data, ref_dm[(b + got) % 256]);
                got++; hold = 0;
            end else if (out_valid) begin
                if (hold > 0 && out_data !== prev) stab_bad++;
                prev = out_data; hold++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("rd_count", got, r);
        cyc = 0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        check("done_seen", done, 1'b1);
        tick();
        end_process = 1'b0;
        check("end_idle", {busy, error, out_valid}, 3'b000);
        check("im_we_count", im_wr_cnt - s_im, n);
        check("dm_we_count", dm_wr_cnt - s_dm, m);
        check("start_count", start_cnt - s_st, 1);
        check("done_count", done_cnt - s_dn, 1);
        check("out_stable", stab_bad, 0);
        check("we_exclusive", both_we, 0);
    endtask

    initial begin
        int sdm;
        #12;
        check("reset_outputs", all_outs(), 72'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_outputs", all_outs(), 72'd0);

        // Nominal session.
        fix_im = '{16'h01, 16'h02, 16'h1F};
        fix_dm = '{16'h0005, 16'h0007};
        fix_cu = '{16'h000C, 16'h0023};
        session(3, 2, 'h10, 2, 20, 0, 100, 1'b0, 0);
        check("nominal_dm10", ref_dm[16], 16'h000C);

        // Input gaps and output stalls.
        session(5, 6, $urandom_range(255), 4, 10, 5, 50, 1'b0, 0);

        // Bad headers, then recovery from ERR.
        session(0, 1, 0, 1, 5, 0, 100, 1'b0, 0);
        session(2, 1, 0, 300, 5, 0, 100, 1'b0, 0);
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check("err_recover", {busy, error, in_ready}, 3'b101);
        session(2, 2, 'h40, 1, 4, 0, 80, 1'b0, 0);

        // Control unit never finishes.
        session(1, 0, 0, 1, 5, 0, 100, 1'b1, 0);

        // Address wrap, then empty DM and empty result window.
        session(2, 3, 'hFE, 3, 8, 1, 70, 1'b0, 0);
        session(2, 0, 0, 0, 0, 0, 100, 1'b0, 0);

        // Reset in the middle of LOAD_DM.
        session(3, 5, 0, 1, 10, 0, 100, 1'b0, 4 + 3 + 2);
        in_valid = 1'b1; in_data = 16'hBEEF;
        check("mid_dm_we", dm_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 72'd0);
        sdm = dm_wr_cnt;
        tick(); tick(); tick();
        check("reset_no_writes", dm_wr_cnt - sdm, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        session(4, 4, 'h80, 2, 6, 2, 60, 1'b0, 0);

        // Full-depth program and oversized DM length.
        session(256, 1, 'hFF, 1, 5, 2, 90, 1'b0, 0);
        session(1, 257, 0, 0, 5, 0, 100, 1'b0, 0);

        // A few random sessions.
        for (int s = 0; s < 3; s++) begin
            int rr;
            rr = $urandom_range(1, 6);
            session($urandom_range(1, 12), $urandom_range(0, 12), $urandom_range(255), rr,
                    rr + $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(40, 100), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
